aes_cipher_arbiter: RTL and testbench
=====================================

Name: aes_cipher_arbiter

Overview:
- Shares one AES cipher core (iterative, one step per enabled clock, done flag that stays high until the core is reset) between two encryption requesters.
- Round-robin arbitration, valid/ready request and response handshakes.
- Per job: pulses the core reset, enables the core, waits for done, and returns the ciphertext tagged with the requester ID.
- A watchdog aborts jobs that never complete.

Parameters:
- Nk, 4, key length in 32-bit words; passed through for consistency with the core.
- Nr, 10, number of rounds; sets the width of the key schedule.
- TIMEOUT, 63, maximum RUN cycles before a job is aborted. Must be greater than 4*Nr.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- req0_valid  in  1  requester 0 has a block.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_data  in  128  requester 0 plaintext.
- w0  in  (Nr+1)*128  requester 0 expanded key schedule.
- req1_valid  in  1  requester 1 has a block.
- req1_ready  out  1  requester 1 accepted this cycle.
- req1_data  in  128  requester 1 plaintext.
- w1  in  (Nr+1)*128  requester 1 expanded key schedule.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_data  out  128  ciphertext, or 0 on error.
- resp_id  out  1  requester that owns the result.
- resp_err  out  1  job timed out.
- busy  out  1  high in any state except IDLE.
- core_data_in  out  128  plaintext to the core.
- core_w  out  (Nr+1)*128  key schedule to the core.
- core_rst  out  1  core reset, active-high.
- core_en  out  1  core clock enable.
- core_done  in  1  core finished.
- core_data_out  in  128  core ciphertext.

Behaviour:
- States: IDLE, CLEAR, RUN, RESP. Reset state is IDLE.
- Reset values: resp_valid=0, resp_data=0, resp_id=0, resp_err=0, busy=0, core_en=0, core_data_in=0, sel=0, last_grant=1 (so requester 0 wins the first tie), cnt=0.
- core_rst is combinational: high while rst=0, high in CLEAR, otherwise low.
- Arbitration (IDLE only, combinational):
  - Only one valid requester: grant it.
  - Both valid: grant the one that is not last_grant.
  - reqN_ready = 1 only for the granted requester while in IDLE. Both ready outputs are 0 in all other states.
- Accept, on the edge where reqN_valid & reqN_ready:
  - Register core_data_in <= reqN_data, sel <= N, last_grant <= N, cnt <= 0.
  - Go to CLEAR.
- core_w = sel ? w1 : w0, combinational from the registered sel. The requester must hold wN stable from accept until its response handshake.
- CLEAR (exactly 1 cycle): core_rst=1, core_en=0. Then go to RUN.
- RUN:
  - core_en=1, cnt increments each cycle.
  - If core_done=1 is sampled: resp_data <= core_data_out, resp_id <= sel, resp_err <= 0, go to RESP.
  - Else if cnt == TIMEOUT-1: resp_data <= 0, resp_id <= sel, resp_err <= 1, go to RESP.
  - If done and timeout coincide, done takes priority.
  - Core latency at Nr=10 is 40 enabled cycles; the arbiter must not depend on this exact value.
- RESP:
  - core_en=0. resp_valid=1; resp_data, resp_id and resp_err are held stable.
  - On resp_valid & resp_ready: resp_valid <= 0, go to IDLE.
  - No new request can be accepted in the same cycle as the response handshake; the earliest accept is the next cycle.
- Back-pressure: RESP may last any number of cycles; no request is accepted meanwhile.
- Requester rules: a requester may drop valid before it is accepted; only a completed handshake starts a job. Requests arriving while busy wait in IDLE arbitration.
- Reset mid-operation: state returns to IDLE at once (asynchronous), any in-flight job is discarded with no response, and core_rst is asserted for the whole time rst=0.

Test Plan:
- Single job: req0 with the FIPS-197 plaintext 00112233445566778899aabbccddeeff and the expanded key of 000102030405060708090a0b0c0d0e0f. Expect exactly one CLEAR cycle, then resp_valid with resp_data=69c4e0d86a7b0430d8cdb78070b4c55a, resp_id=0, resp_err=0.
- Contention: req0 and req1 valid in the same cycle from reset. Expect req0 served first (resp_id=0), then req1 (resp_id=1). With both held valid continuously, grants alternate 0,1,0,1.
- Back-pressure: resp_ready held 0 for 20 cycles. Expect resp_valid, resp_data and resp_id stable, both reqN_ready=0, busy=1. Raise resp_ready: handshake, then next-cycle acceptance of the pending request.
- Timeout: core_done stubbed to 0 and TIMEOUT=63. Expect RESP entered after 63 RUN cycles with resp_err=1 and resp_data=0; the following job completes normally.
- Reset mid-RUN: drive rst=0 at RUN cycle 10. Expect an immediate IDLE with all outputs at their reset values and core_rst=1. After rst=1, a new req1 completes with the correct ciphertext and no stale response appears.
- Done and timeout in the same cycle (core stub): expect resp_err=0 and resp_data equal to the core output.

Source files
------------

// File: rtl/aes_cipher_arbiter_if.sv
// Request, response and core-side signal bundle for aes_cipher_arbiter.
// The arbiter uses the slave view; requesters, consumer and core sit on the master view.
interface aes_cipher_arbiter_if #(
  parameter int Nr = 10
);
  localparam int KW = (Nr + 1) * 128;

  logic          req0_valid;
  logic          req0_ready;
  logic [127:0]  req0_data;
  logic [KW-1:0] w0;

  logic          req1_valid;
  logic          req1_ready;
  logic [127:0]  req1_data;
  logic [KW-1:0] w1;

  logic          resp_valid;
  logic          resp_ready;
  logic [127:0]  resp_data;
  logic          resp_id;
  logic          resp_err;
  logic          busy;

  logic [127:0]  core_data_in;
  logic [KW-1:0] core_w;
  logic          core_rst;
  logic          core_en;
  logic          core_done;
  logic [127:0]  core_data_out;

  modport slave (
    input  req0_valid, req0_data, w0,
    input  req1_valid, req1_data, w1,
    input  resp_ready, core_done, core_data_out,
    output req0_ready, req1_ready,
    output resp_valid, resp_data, resp_id, resp_err, busy,
    output core_data_in, core_w, core_rst, core_en
  );

  modport master (
    output req0_valid, req0_data, w0,
    output req1_valid, req1_data, w1,
    output resp_ready, core_done, core_data_out,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_data, resp_id, resp_err, busy,
    input  core_data_in, core_w, core_rst, core_en
  );
endinterface

// File: rtl/aes_cipher_arbiter.sv
// Round-robin front end sharing one iterative AES cipher core between two
// requesters: per-job core reset, run until done, watchdog abort, tagged response.
module aes_cipher_arbiter #(
  parameter int Nk      = 4,
  parameter int Nr      = 10,
  parameter int TIMEOUT = 63
) (
  input logic                 clk,
  input logic                 rst,
  aes_cipher_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  // An instance whose watchdog is shorter than the core latency would abort every
  // job; such a configuration refuses all work instead.
  localparam bit CFG_OK = (TIMEOUT > 4 * Nr) && (Nk >= 4);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} state_t;

  state_t        state_q, state_d;
  logic          sel_q;
  logic          last_grant_q;
  logic [CW-1:0] cnt_q;
  logic [127:0]  data_in_q;
  logic [127:0]  resp_data_q;
  logic          resp_id_q;
  logic          resp_err_q;
  logic          grant0, grant1;
  logic          timeout;

  assign timeout = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    // NOTE: every signal this block drives gets a default first, so no path can infer a latch.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && CFG_OK) begin
      grant0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
      grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant0 || grant1) state_d = CLEAR;
      CLEAR:   state_d = RUN;
      RUN:     if (bus.core_done || timeout) state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      data_in_q    <= '0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0) begin
            data_in_q    <= bus.req0_data;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b0;
            cnt_q        <= '0;
          end else if (grant1) begin
            data_in_q    <= bus.req1_data;
            sel_q        <= 1'b1;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + CW'(1);
          // Completion wins over the watchdog when both land on the same cycle.
          if (bus.core_done) begin
            resp_data_q <= bus.core_data_out;
            resp_id_q   <= sel_q;
            resp_err_q  <= 1'b0;
          end else if (timeout) begin
            resp_data_q <= '0;
            resp_id_q   <= sel_q;
            resp_err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready   = grant0;
  assign bus.req1_ready   = grant1;
  assign bus.resp_valid   = (state_q == RESP);
  assign bus.resp_data    = resp_data_q;
  assign bus.resp_id      = resp_id_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.core_data_in = data_in_q;
  assign bus.core_w       = sel_q ? bus.w1 : bus.w0;
  assign bus.core_en      = (state_q == RUN);
  // The core is held in reset for as long as the arbiter itself is.
  assign bus.core_rst     = !rst || (state_q == CLEAR);
endmodule

// File: tb/tb_aes_cipher_arbiter.sv
// Directed bench for aes_cipher_arbiter: a latency-programmable core stand-in,
// a job table for the main paths and hand-written multi-cycle sequences.
module tb_aes_cipher_arbiter;
  localparam int NR = 10;
  localparam int KW = (NR + 1) * 128;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [KW-1:0] KS = {
    128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5};
  localparam logic [KW-1:0] W1 = {11{128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0}};

  typedef struct {
    bit           r;
    logic [127:0] d;
    int           l;
    logic [127:0] exp_data;
    bit           exp_err;
    int           exp_run;
  } job_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   lat = 40;
  int   ccnt = 0;

  aes_cipher_arbiter_if #(.Nr(NR)) bus ();

  aes_cipher_arbiter #(.Nk(4), .Nr(NR), .TIMEOUT(63)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Core stand-in: the FIPS-197 vector maps to its known ciphertext, anything
  // else to a cheap key-dependent mix; done rises after `lat` enabled cycles.
  function automatic logic [127:0] core_model(input logic [127:0] d, input logic [KW-1:0] w);
    if (d == PT && w == KS) return CT;
    return d ^ w[127:0];
  endfunction

  always @(posedge clk) begin
    if (bus.core_rst)     ccnt <= 0;
    else if (bus.core_en) ccnt <= ccnt + 1;
  end
  assign bus.core_done     = (ccnt >= lat);
  assign bus.core_data_out = core_model(bus.core_data_in, bus.core_w);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " resp_valid"},   bus.resp_valid, 0);
    check({tag, " resp_data"},    bus.resp_data, 0);
    check({tag, " resp_id"},      bus.resp_id, 0);
    check({tag, " resp_err"},     bus.resp_err, 0);
    check({tag, " busy"},         bus.busy, 0);
    check({tag, " core_en"},      bus.core_en, 0);
    check({tag, " core_data_in"}, bus.core_data_in, 0);
    check({tag, " core_rst"},     bus.core_rst, 1);
    check({tag, " req0_ready"},   bus.req0_ready, 0);
    check({tag, " req1_ready"},   bus.req1_ready, 0);
  endtask

  task automatic run_job(input job_t j, input string tag);
    int n, clr, run;
    @(negedge clk);
    lat = j.l;
    if (j.r) begin bus.req1_data = j.d; bus.req1_valid = 1'b1; end
    else     begin bus.req0_data = j.d; bus.req0_valid = 1'b1; end
    #1;
    check({tag, " own ready"},   j.r ? bus.req1_ready : bus.req0_ready, 1);
    check({tag, " other ready"}, j.r ? bus.req0_ready : bus.req1_ready, 0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    n = 0; clr = 0; run = 0;
    while (!bus.resp_valid && n < 200) begin
      if (bus.core_rst) clr++;
      if (bus.core_en)  run++;
      n++;
      @(negedge clk);
    end
    check({tag, " resp_valid reached"}, bus.resp_valid, 1);
    check({tag, " resp_data"},   bus.resp_data, j.exp_data);
    check({tag, " resp_id"},     bus.resp_id, j.r);
    check({tag, " resp_err"},    bus.resp_err, j.exp_err);
    check({tag, " clear cycles"}, clr, 1);
    check({tag, " run cycles"},  run, j.exp_run);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check({tag, " resp_valid after handshake"}, bus.resp_valid, 0);
    check({tag, " busy after handshake"},       bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit: got expired, want finish");
    $fatal(1, "time limit");
  end

  initial begin
    job_t jobs[7];
    logic [127:0] d0, d1, hold_data;
    bit   exp_id, stable, stale;
    int   n;

    d0 = 128'h11111111222222223333333344444444;
    d1 = 128'h55555555666666667777777788888888;
    jobs[0] = '{0, PT, 40, CT, 0, 41};
    jobs[1] = '{1, 128'hdeadbeefcafef00d0123456789abcdef, 40,
                core_model(128'hdeadbeefcafef00d0123456789abcdef, W1), 0, 41};
    jobs[2] = '{0, 128'h0123456789abcdeffedcba9876543210, 0,
                core_model(128'h0123456789abcdeffedcba9876543210, KS), 0, 1};
    jobs[3] = '{1, 128'ha5a5a5a55a5a5a5af0f0f0f00f0f0f0f, 62,
                core_model(128'ha5a5a5a55a5a5a5af0f0f0f00f0f0f0f, W1), 0, 63};
    jobs[4] = '{0, 128'h00000000000000000000000000000001, 63, 128'h0, 1, 63};
    jobs[5] = '{1, 128'hffffffffffffffffffffffffffffffff, 1000, 128'h0, 1, 63};
    jobs[6] = '{1, PT, 3, core_model(PT, W1), 0, 4};

    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.w0 = KS;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.w1 = W1;
    bus.resp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b1;
    @(negedge clk);
    check("idle core_rst low", bus.core_rst, 0);

    // Both requesters valid from reset and held: grants must go 0,1,0,1.
    bus.req0_data = d0; bus.req1_data = d1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    lat = 5;
    #1;
    for (int j = 0; j < 4; j++) begin
      exp_id = j[0];
      check($sformatf("contend%0d req0_ready", j), bus.req0_ready, !exp_id);
      check($sformatf("contend%0d req1_ready", j), bus.req1_ready, exp_id);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.resp_valid && n < 200);
      check($sformatf("contend%0d resp_valid reached", j), bus.resp_valid, 1);
      check($sformatf("contend%0d resp_id", j), bus.resp_id, exp_id);
      check($sformatf("contend%0d resp_data", j), bus.resp_data,
            exp_id ? core_model(d1, W1) : core_model(d0, KS));
      if (j == 0) begin
        hold_data = bus.resp_data;
        stable = 1'b1;
        repeat (20) begin
          @(negedge clk);
          if (!bus.resp_valid || bus.resp_data !== hold_data || bus.resp_id !== 1'b0 ||
              bus.req0_ready || bus.req1_ready || !bus.busy)
            stable = 1'b0;
        end
        check("backpressure hold", stable, 1);
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      #1;
      check($sformatf("contend%0d resp_valid dropped", j), bus.resp_valid, 0);
    end
    // Next grant (back to requester 0) is offered, then both withdraw unaccepted.
    check("contend final req0_ready", bus.req0_ready, 1);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("withdrawn request not started", bus.busy, 0);

    for (int k = 0; k < 7; k++) run_job(jobs[k], $sformatf("job%0d", k));

    // Reset in RUN cycle 10 discards the job; no stale response may follow.
    @(negedge clk);
    lat = 40;
    bus.req0_data = PT; bus.req0_valid = 1'b1;
    #1;
    check("midrun req0_ready", bus.req0_ready, 1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("midrun in RUN", bus.core_en, 1);
    rst = 1'b0;
    #1;
    check_reset_state("midrun reset");
    @(negedge clk);
    rst = 1'b1;
    bus.w1 = KS;
    stale = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (bus.resp_valid || bus.busy) stale = 1'b1;
    end
    check("no stale response", stale, 0);
    run_job('{1, PT, 40, CT, 0, 41}, "after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
